// File: rtl/axi_arbiter_nx1.sv
// axi_arbiter_nx1: N-master to 1-slave AXI3 arbiter.
// Read and write arbitrate independently, one outstanding transaction per
// direction. Responses are routed by the registered owner index, never by ID.
// Optional macro ARB_RR_EN selects round-robin arbitration. Without it,
// arbitration is fixed priority and the lowest master index wins.
module axi_arbiter_nx1 #(
  parameter int N_MASTER = 3,
  parameter int ID_W     = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  // slave-side AR
  input  logic [N_MASTER*ID_W-1:0]          s_arid,
  input  logic [N_MASTER*ADDR_W-1:0]        s_araddr,
  input  logic [N_MASTER*4-1:0]             s_arlen,
  input  logic [N_MASTER*3-1:0]             s_arsize,
  input  logic [N_MASTER*2-1:0]             s_arburst,
  input  logic [N_MASTER*2-1:0]             s_arlock,
  input  logic [N_MASTER*4-1:0]             s_arcache,
  input  logic [N_MASTER*3-1:0]             s_arprot,
  input  logic [N_MASTER-1:0]               s_arvalid,
  output logic [N_MASTER-1:0]               s_arready,
  // slave-side R
  output logic [N_MASTER*ID_W-1:0]          s_rid,
  output logic [N_MASTER*DATA_W-1:0]        s_rdata,
  output logic [N_MASTER*2-1:0]             s_rresp,
  output logic [N_MASTER-1:0]               s_rlast,
  output logic [N_MASTER-1:0]               s_rvalid,
  input  logic [N_MASTER-1:0]               s_rready,
  // slave-side AW
  input  logic [N_MASTER*ID_W-1:0]          s_awid,
  input  logic [N_MASTER*ADDR_W-1:0]        s_awaddr,
  input  logic [N_MASTER*4-1:0]             s_awlen,
  input  logic [N_MASTER*3-1:0]             s_awsize,
  input  logic [N_MASTER*2-1:0]             s_awburst,
  input  logic [N_MASTER*2-1:0]             s_awlock,
  input  logic [N_MASTER*4-1:0]             s_awcache,
  input  logic [N_MASTER*3-1:0]             s_awprot,
  input  logic [N_MASTER-1:0]               s_awvalid,
  output logic [N_MASTER-1:0]               s_awready,
  // slave-side W
  input  logic [N_MASTER*ID_W-1:0]          s_wid,
  input  logic [N_MASTER*DATA_W-1:0]        s_wdata,
  input  logic [N_MASTER*(DATA_W/8)-1:0]    s_wstrb,
  input  logic [N_MASTER-1:0]               s_wlast,
  input  logic [N_MASTER-1:0]               s_wvalid,
  output logic [N_MASTER-1:0]               s_wready,
  // slave-side B
  output logic [N_MASTER*ID_W-1:0]          s_bid,
  output logic [N_MASTER*2-1:0]             s_bresp,
  output logic [N_MASTER-1:0]               s_bvalid,
  input  logic [N_MASTER-1:0]               s_bready,
  // master-side AR
  output logic [ID_W-1:0]                   m_arid,
  output logic [ADDR_W-1:0]                 m_araddr,
  output logic [3:0]                        m_arlen,
  output logic [2:0]                        m_arsize,
  output logic [1:0]                        m_arburst,
  output logic [1:0]                        m_arlock,
  output logic [3:0]                        m_arcache,
  output logic [2:0]                        m_arprot,
  output logic [3:0]                        m_arqos,
  output logic                              m_arvalid,
  input  logic                              m_arready,
  // master-side R
  input  logic [ID_W-1:0]                   m_rid,
  input  logic [DATA_W-1:0]                 m_rdata,
  input  logic [1:0]                        m_rresp,
  input  logic                              m_rlast,
  input  logic                              m_rvalid,
  output logic                              m_rready,
  // master-side AW
  output logic [ID_W-1:0]                   m_awid,
  output logic [ADDR_W-1:0]                 m_awaddr,
  output logic [3:0]                        m_awlen,
  output logic [2:0]                        m_awsize,
  output logic [1:0]                        m_awburst,
  output logic [1:0]                        m_awlock,
  output logic [3:0]                        m_awcache,
  output logic [2:0]                        m_awprot,
  output logic [3:0]                        m_awqos,
  output logic                              m_awvalid,
  input  logic                              m_awready,
  // master-side W
  output logic [ID_W-1:0]                   m_wid,
  output logic [DATA_W-1:0]                 m_wdata,
  output logic [DATA_W/8-1:0]               m_wstrb,
  output logic                              m_wlast,
  output logic                              m_wvalid,
  input  logic                              m_wready,
  // master-side B
  input  logic [ID_W-1:0]                   m_bid,
  input  logic [1:0]                        m_bresp,
  input  logic                              m_bvalid,
  output logic                              m_bready
);

  localparam int OWN_W  = $clog2(N_MASTER);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;

  r_state_e         r_state_reg;
  w_state_e         w_state_reg;
  logic [OWN_W-1:0] r_own_reg, w_own_reg;
  logic             aw_done_reg, w_done_reg;
  logic [OWN_W-1:0] r_grant, w_grant;
  logic [31:0]      r_sel, w_sel;
  logic             aw_fire, w_last_fire;

  // Search for the first requester at or above ptr, wrapping to index 0.
  // With ptr = 0 this degenerates to lowest-index-wins.
  function automatic logic [OWN_W-1:0] pick(input logic [N_MASTER-1:0] req,
                                            input logic [OWN_W-1:0]    ptr);
    logic [OWN_W-1:0] pick_hi, pick_lo;
    logic             found_hi;
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    for (int j = N_MASTER - 1; j >= 0; j--) begin
      if (req[j]) pick_lo = OWN_W'(j);
      if (req[j] && (j >= int'(ptr))) begin
        pick_hi  = OWN_W'(j);
        found_hi = 1'b1;
      end
    end
    return found_hi ? pick_hi : pick_lo;
  endfunction

`ifdef ARB_RR_EN
  logic [OWN_W-1:0] r_ptr_reg, w_ptr_reg;
  assign r_grant = pick(s_arvalid, r_ptr_reg);
  assign w_grant = pick(s_awvalid, w_ptr_reg);
`else
  assign r_grant = pick(s_arvalid, '0);
  assign w_grant = pick(s_awvalid, '0);
`endif

  assign r_sel = 32'(r_own_reg);
  assign w_sel = 32'(w_own_reg);

  // Read FSM: grant, forward AR of the owner, then route R until rlast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_reg <= R_IDLE;
      r_own_reg   <= '0;
`ifdef ARB_RR_EN
      r_ptr_reg   <= '0;
`endif
    end else begin
      case (r_state_reg)
        R_IDLE: if (|s_arvalid) begin
          r_own_reg   <= r_grant;
          r_state_reg <= R_ADDR;
`ifdef ARB_RR_EN
          r_ptr_reg   <= (r_grant == OWN_W'(N_MASTER - 1)) ? '0 : r_grant + 1'b1;
`endif
        end
        R_ADDR: if (m_arvalid && m_arready) r_state_reg <= R_DATA;
        R_DATA: if (m_rvalid && m_rready && m_rlast) r_state_reg <= R_IDLE;
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  assign aw_fire     = m_awvalid && m_awready;
  assign w_last_fire = m_wvalid && m_wready && m_wlast;

  // Write FSM: grant, run AW and W concurrently with sticky done flags, then B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
      w_own_reg   <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
`ifdef ARB_RR_EN
      w_ptr_reg   <= '0;
`endif
    end else begin
      case (w_state_reg)
        W_IDLE: if (|s_awvalid) begin
          w_own_reg   <= w_grant;
          w_state_reg <= W_ADDR;
`ifdef ARB_RR_EN
          w_ptr_reg   <= (w_grant == OWN_W'(N_MASTER - 1)) ? '0 : w_grant + 1'b1;
`endif
        end
        W_ADDR: begin
          if (aw_fire)     aw_done_reg <= 1'b1;
          if (w_last_fire) w_done_reg  <= 1'b1;
          if ((aw_done_reg || aw_fire) && (w_done_reg || w_last_fire))
            w_state_reg <= W_RESP;
        end
        W_RESP: if (m_bvalid && m_bready) begin
          w_state_reg <= W_IDLE;
          aw_done_reg <= 1'b0;
          w_done_reg  <= 1'b0;
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  // Master-port request channels: combinational mux of the current owner.
  assign m_arid    = s_arid   [r_sel*ID_W   +: ID_W];
  assign m_araddr  = s_araddr [r_sel*ADDR_W +: ADDR_W];
  assign m_arlen   = s_arlen  [r_sel*4 +: 4];
  assign m_arsize  = s_arsize [r_sel*3 +: 3];
  assign m_arburst = s_arburst[r_sel*2 +: 2];
  assign m_arlock  = s_arlock [r_sel*2 +: 2];
  assign m_arcache = s_arcache[r_sel*4 +: 4];
  assign m_arprot  = s_arprot [r_sel*3 +: 3];
  assign m_arqos   = 4'd0;
  assign m_arvalid = (r_state_reg == R_ADDR) && s_arvalid[r_own_reg];
  assign m_rready  = (r_state_reg == R_DATA) && s_rready[r_own_reg];

  assign m_awid    = s_awid   [w_sel*ID_W   +: ID_W];
  assign m_awaddr  = s_awaddr [w_sel*ADDR_W +: ADDR_W];
  assign m_awlen   = s_awlen  [w_sel*4 +: 4];
  assign m_awsize  = s_awsize [w_sel*3 +: 3];
  assign m_awburst = s_awburst[w_sel*2 +: 2];
  assign m_awlock  = s_awlock [w_sel*2 +: 2];
  assign m_awcache = s_awcache[w_sel*4 +: 4];
  assign m_awprot  = s_awprot [w_sel*3 +: 3];
  assign m_awqos   = 4'd0;
  assign m_awvalid = (w_state_reg == W_ADDR) && !aw_done_reg && s_awvalid[w_own_reg];

  assign m_wid     = s_wid  [w_sel*ID_W   +: ID_W];
  assign m_wdata   = s_wdata[w_sel*DATA_W +: DATA_W];
  assign m_wstrb   = s_wstrb[w_sel*STRB_W +: STRB_W];
  assign m_wlast   = s_wlast[w_own_reg];
  assign m_wvalid  = (w_state_reg == W_ADDR) && !w_done_reg && s_wvalid[w_own_reg];
  assign m_bready  = (w_state_reg == W_RESP) && s_bready[w_own_reg];

  // Per-master routing: handshake qualifiers only reach the owner; response
  // payloads are broadcast unqualified.
  genvar gi;
  generate
    for (gi = 0; gi < N_MASTER; gi++) begin : g_port
      logic r_mine, w_mine;
      assign r_mine = (r_own_reg == OWN_W'(gi));
      assign w_mine = (w_own_reg == OWN_W'(gi));

      assign s_arready[gi] = (r_state_reg == R_ADDR) && r_mine && m_arready;
      assign s_rvalid[gi]  = (r_state_reg == R_DATA) && r_mine && m_rvalid;
      assign s_rid  [gi*ID_W   +: ID_W]   = m_rid;
      assign s_rdata[gi*DATA_W +: DATA_W] = m_rdata;
      assign s_rresp[gi*2 +: 2]           = m_rresp;
      assign s_rlast[gi]                  = m_rlast;

      assign s_awready[gi] = (w_state_reg == W_ADDR) && w_mine && !aw_done_reg && m_awready;
      assign s_wready[gi]  = (w_state_reg == W_ADDR) && w_mine && !w_done_reg && m_wready;
      assign s_bvalid[gi]  = (w_state_reg == W_RESP) && w_mine && m_bvalid;
      assign s_bid  [gi*ID_W +: ID_W]     = m_bid;
      assign s_bresp[gi*2 +: 2]           = m_bresp;
    end
  endgenerate

endmodule

// File: tb/tb_axi_arbiter_nx1.sv
// tb_axi_arbiter_nx1: directed self-checking bench for axi_arbiter_nx1 (N=3).
// Expected arbitration order depends on whether ARB_RR_EN is defined.
module tb_axi_arbiter_nx1;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*4-1:0]  s_arid, s_arlen, s_arcache, s_awid, s_awlen, s_awcache, s_wid, s_wstrb;
  logic [N*32-1:0] s_araddr, s_awaddr, s_wdata;
  logic [N*3-1:0]  s_arsize, s_arprot, s_awsize, s_awprot;
  logic [N*2-1:0]  s_arburst, s_arlock, s_awburst, s_awlock;
  logic [N-1:0]    s_arvalid, s_arready, s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic [N*4-1:0]  s_rid, s_bid;
  logic [N*32-1:0] s_rdata;
  logic [N*2-1:0]  s_rresp, s_bresp;
  logic [N-1:0]    s_rlast, s_rvalid, s_rready, s_bvalid, s_bready;
  logic [3:0]  m_arid, m_arlen, m_arcache, m_arqos, m_awid, m_awlen, m_awcache, m_awqos, m_wid, m_wstrb;
  logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
  logic [2:0]  m_arsize, m_arprot, m_awsize, m_awprot;
  logic [1:0]  m_arburst, m_arlock, m_awburst, m_awlock, m_rresp, m_bresp;
  logic [3:0]  m_rid, m_bid;
  logic m_arvalid, m_arready, m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic m_rlast, m_rvalid, m_rready, m_bvalid, m_bready;

  int n_cmp = 0;
  int n_err = 0;

  axi_arbiter_nx1 #(.N_MASTER(N), .ID_W(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arqos(m_arqos), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awqos(m_awqos), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  task automatic clear_inputs();
    s_arvalid = '0; s_awvalid = '0; s_wvalid = '0; s_wlast = '0;
    s_rready = '0; s_bready = '0;
    m_arready = 0; m_awready = 0; m_wready = 0;
    m_rvalid = 0; m_rlast = 0; m_bvalid = 0; m_rdata = '0; m_rid = '0; m_rresp = '0;
    m_bid = '0; m_bresp = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; clear_inputs();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    m_rvalid = 1; m_bvalid = 1; m_arready = 1; m_awready = 1; m_wready = 1;
    s_rready = '1; s_bready = '1; s_arvalid = 3'b001;
    @(negedge clk); #1;
    n_cmp++;
    if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, s_arready, s_awready,
         s_wready, s_rvalid, s_bvalid} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want all 0", {m_arvalid, m_awvalid, m_wvalid,
               m_rready, m_bready, s_arready, s_awready, s_wready, s_rvalid, s_bvalid});
    end
    n_cmp++;
    if ({m_arqos, m_awqos} !== 8'h00) begin
      n_err++; $display("FAIL reset_qos: got %h want 00", {m_arqos, m_awqos});
    end
    clear_inputs();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({m_arvalid, m_rready, s_rvalid} !== 5'd0) begin
      n_err++; $display("FAIL reset_idle: got %b want 0", {m_arvalid, m_rready, s_rvalid});
    end
    $display("txn reset done");
  endtask

  task automatic test_single_read();
    @(negedge clk);
    s_arvalid = 3'b010; s_araddr[32 +: 32] = 32'h1FC0_0000; s_arlen[4 +: 4] = 4'd3;
    s_arsize[3 +: 3] = 3'd2; s_arburst[2 +: 2] = 2'b01; s_rready = 3'b010;
    #1;
    n_cmp++;
    if (m_arvalid !== 1'b0) begin
      n_err++; $display("FAIL sr_grant_cycle: m_arvalid got %b want 0", m_arvalid);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({m_arvalid, m_araddr, m_arlen, m_arid, m_arsize, m_arburst, s_arready} !==
        {1'b1, 32'h1FC0_0000, 4'd3, 4'd1, 3'd2, 2'b01, 3'b000}) begin
      n_err++;
      $display("FAIL sr_ar_mux: valid %b addr %h len %h id %h size %h burst %b rdy %b want 1 1fc00000 3 1 2 01 000",
               m_arvalid, m_araddr, m_arlen, m_arid, m_arsize, m_arburst, s_arready);
    end
    m_arready = 1; #1;
    n_cmp++;
    if (s_arready !== 3'b010) begin
      n_err++; $display("FAIL sr_arready: got %b want 010", s_arready);
    end
    @(negedge clk);
    s_arvalid = '0; m_arready = 0;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1; m_rdata = 32'hA0 + 32'(b); m_rlast = (b == 3); m_rid = 4'd1; #1;
      n_cmp++;
      if ({s_rvalid, m_rready, s_rdata[32 +: 32], s_rlast[1], s_rid[4 +: 4]} !==
          {3'b010, 1'b1, 32'hA0 + 32'(b), (b == 3), 4'd1}) begin
        n_err++;
        $display("FAIL sr_beat%0d: rvalid %b rready %b data %h last %b id %h want 010 1 %h %b 1",
                 b, s_rvalid, m_rready, s_rdata[32 +: 32], s_rlast[1], s_rid[4 +: 4],
                 32'hA0 + 32'(b), (b == 3));
      end
      @(negedge clk);
    end
    m_rvalid = 0; m_rlast = 0; #1;
    n_cmp++;
    if ({m_rready, s_rvalid} !== 4'b0000) begin
      n_err++; $display("FAIL sr_done_idle: got %b want 0000", {m_rready, s_rvalid});
    end
    s_rready = '0;
    $display("txn read master=1 addr=1fc00000 beats=4");
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    s_arvalid = 3'b001; s_araddr[0 +: 32] = 32'h0000_1000; s_arlen[0 +: 4] = 4'd3; s_rready = 3'b001;
    @(negedge clk); m_arready = 1;
    @(negedge clk); m_arready = 0; s_arvalid = '0;
    m_rvalid = 1; m_rdata = 32'hC0; m_rlast = 0;
    @(negedge clk); m_rdata = 32'hC1; #1;
    n_cmp++;
    if (m_rready !== 1'b1) begin
      n_err++; $display("FAIL rmb_pre_rready: got %b want 1", m_rready);
    end
    rst = 1'b1; s_arvalid = 3'b001; m_arready = 1; #1;
    n_cmp++;
    if ({m_rready, s_rvalid, s_arready, m_arvalid} !== 8'd0) begin
      n_err++; $display("FAIL rmb_async_drop: got %b want 0", {m_rready, s_rvalid, s_arready, m_arvalid});
    end
    @(negedge clk);
    rst = 1'b0; m_rvalid = 0; m_arready = 0; s_araddr[0 +: 32] = 32'h0000_2000; #1;
    n_cmp++;
    if (m_arvalid !== 1'b0) begin
      n_err++; $display("FAIL rmb_regrant_cycle: m_arvalid got %b want 0", m_arvalid);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({m_arvalid, m_araddr} !== {1'b1, 32'h0000_2000}) begin
      n_err++; $display("FAIL rmb_regrant: valid %b addr %h want 1 00002000", m_arvalid, m_araddr);
    end
    m_arready = 1;
    @(negedge clk);
    m_arready = 0; s_arvalid = '0; m_rvalid = 1; m_rlast = 1; m_rdata = 32'hD0; #1;
    n_cmp++;
    if (s_rvalid !== 3'b001) begin
      n_err++; $display("FAIL rmb_new_beat: s_rvalid got %b want 001", s_rvalid);
    end
    @(negedge clk); m_rvalid = 0; m_rlast = 0; s_rready = '0;
    $display("txn read master=0 reset mid-burst then addr=00002000");
  endtask

  task automatic test_arbitration();
    int exp_order [4];
    bit ok;
`ifdef ARB_RR_EN
    exp_order = '{0, 1, 2, 1};
`else
    exp_order = '{0, 0, 0, 1};
`endif
    do_reset();
    for (int m = 0; m < N; m++) begin
      s_araddr[m*32 +: 32] = 32'(m) << 8;
      s_arid[m*4 +: 4] = 4'(m);
      s_arlen[m*4 +: 4] = 4'd0;
    end
    s_arvalid = 3'b111; s_rready = 3'b111;
    for (int t = 0; t < 4; t++) begin
      ok = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk); #1;
        if (m_arvalid) begin ok = 1; break; end
      end
      n_cmp++;
      if (!ok) begin
        n_err++; $display("FAIL arb_timeout%0d: m_arvalid got 0 want 1", t);
      end
      n_cmp++;
      if ({m_araddr[11:8], m_arid} !== {4'(exp_order[t]), 4'(exp_order[t])}) begin
        n_err++; $display("FAIL arb_order%0d: owner %0d id %0d want %0d", t, m_araddr[11:8], m_arid, exp_order[t]);
      end
      m_arready = 1; #1;
      n_cmp++;
      if (s_arready !== 3'(1 << exp_order[t])) begin
        n_err++; $display("FAIL arb_ready%0d: got %b want %b", t, s_arready, 3'(1 << exp_order[t]));
      end
      @(negedge clk);
      m_arready = 0;
      if (t == 2) s_arvalid[0] = 1'b0;
      if (t == 3) s_arvalid = '0;
      m_rvalid = 1; m_rlast = 1; #1;
      n_cmp++;
      if (s_rvalid !== 3'(1 << exp_order[t])) begin
        n_err++; $display("FAIL arb_rvalid%0d: got %b want %b", t, s_rvalid, 3'(1 << exp_order[t]));
      end
      @(negedge clk); m_rvalid = 0; m_rlast = 0;
      $display("txn arb read grant=%0d", exp_order[t]);
    end
    s_rready = '0;
  endtask

  task automatic test_write_w_before_aw();
    @(negedge clk);
    s_awvalid = 3'b100; s_awaddr[64 +: 32] = 32'h0000_3000; s_awid[8 +: 4] = 4'd2;
    s_wvalid = 3'b100; s_wdata[64 +: 32] = 32'hDEAD_BEEF; s_wstrb[8 +: 4] = 4'hF;
    s_wlast = 3'b100; s_bready = 3'b100; m_wready = 1; m_awready = 0; #1;
    n_cmp++;
    if ({m_awvalid, m_wvalid} !== 2'b00) begin
      n_err++; $display("FAIL wb_grant_cycle: got %b want 00", {m_awvalid, m_wvalid});
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({m_awvalid, m_wvalid, m_wdata, m_wstrb, m_wlast, s_wready, s_awready} !==
        {1'b1, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 3'b100, 3'b000}) begin
      n_err++;
      $display("FAIL wb_w_mux: awv %b wv %b data %h strb %h last %b wrdy %b awrdy %b want 1 1 deadbeef f 1 100 000",
               m_awvalid, m_wvalid, m_wdata, m_wstrb, m_wlast, s_wready, s_awready);
    end
    @(negedge clk);
    s_wvalid = '0; #1;
    n_cmp++;
    if ({m_awvalid, m_wvalid, s_wready, m_bready} !== {1'b1, 1'b0, 3'b000, 1'b0}) begin
      n_err++; $display("FAIL wb_w_done: got %b want 1 0 000 0", {m_awvalid, m_wvalid, s_wready, m_bready});
    end
    @(negedge clk); #1;
    n_cmp++;
    if (m_bready !== 1'b0) begin
      n_err++; $display("FAIL wb_bready_early: got %b want 0", m_bready);
    end
    m_awready = 1; #1;
    n_cmp++;
    if ({s_awready, m_awaddr} !== {3'b100, 32'h0000_3000}) begin
      n_err++; $display("FAIL wb_aw_hs: rdy %b addr %h want 100 00003000", s_awready, m_awaddr);
    end
    @(negedge clk);
    m_awready = 0; m_wready = 0; s_awvalid = '0; s_wlast = '0; #1;
    n_cmp++;
    if ({m_awvalid, m_bready, s_bvalid} !== 5'b01000) begin
      n_err++; $display("FAIL wb_resp_state: got %b want 01000", {m_awvalid, m_bready, s_bvalid});
    end
    m_bvalid = 1; m_bresp = 2'b00; m_bid = 4'd2; #1;
    n_cmp++;
    if ({s_bvalid, s_bresp[4 +: 2], s_bid[8 +: 4]} !== {3'b100, 2'b00, 4'd2}) begin
      n_err++; $display("FAIL wb_b_route: valid %b resp %b id %h want 100 00 2", s_bvalid, s_bresp[4 +: 2], s_bid[8 +: 4]);
    end
    @(negedge clk); m_bvalid = 0; #1;
    n_cmp++;
    if (m_bready !== 1'b0) begin
      n_err++; $display("FAIL wb_idle: m_bready got %b want 0", m_bready);
    end
    s_bready = '0;
    $display("txn write master=2 data=deadbeef bresp=0");
  endtask

  task automatic test_concurrent();
    @(negedge clk);
    s_arvalid = 3'b001; s_araddr[0 +: 32] = 32'h0000_4000;
    s_awvalid = 3'b010; s_awaddr[32 +: 32] = 32'h0000_5000;
    s_wvalid = 3'b010; s_wlast = 3'b010; s_wdata[32 +: 32] = 32'h1234_5678; s_wstrb[4 +: 4] = 4'hF;
    s_rready = 3'b001; s_bready = 3'b010; #1;
    n_cmp++;
    if ({m_arvalid, m_awvalid} !== 2'b00) begin
      n_err++; $display("FAIL cc_grant_cycle: got %b want 00", {m_arvalid, m_awvalid});
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({m_arvalid, m_awvalid, m_araddr, m_awaddr} !== {2'b11, 32'h0000_4000, 32'h0000_5000}) begin
      n_err++; $display("FAIL cc_both_valid: v %b ar %h aw %h want 11 00004000 00005000",
                        {m_arvalid, m_awvalid}, m_araddr, m_awaddr);
    end
    m_arready = 1; m_awready = 1; m_wready = 1; #1;
    n_cmp++;
    if ({s_arready, s_awready, s_wready} !== {3'b001, 3'b010, 3'b010}) begin
      n_err++; $display("FAIL cc_readies: got %b want 001010010", {s_arready, s_awready, s_wready});
    end
    @(negedge clk);
    s_arvalid = '0; s_awvalid = '0; s_wvalid = '0; s_wlast = '0;
    m_arready = 0; m_awready = 0; m_wready = 0; #1;
    n_cmp++;
    if ({m_rready, m_bready, m_awvalid, m_wvalid} !== 4'b1100) begin
      n_err++; $display("FAIL cc_single_beat_resp: got %b want 1100", {m_rready, m_bready, m_awvalid, m_wvalid});
    end
    m_rvalid = 1; m_rlast = 1; m_bvalid = 1; m_bresp = 2'b00; #1;
    n_cmp++;
    if ({s_rvalid, s_bvalid} !== {3'b001, 3'b010}) begin
      n_err++; $display("FAIL cc_resp_route: got %b want 001010", {s_rvalid, s_bvalid});
    end
    @(negedge clk); m_rvalid = 0; m_rlast = 0; m_bvalid = 0; #1;
    n_cmp++;
    if ({m_rready, m_bready} !== 2'b00) begin
      n_err++; $display("FAIL cc_idle: got %b want 00", {m_rready, m_bready});
    end
    s_rready = '0; s_bready = '0;
    $display("txn concurrent read master=0 write master=1");
  endtask

  task automatic test_backpressure();
    int rx;
    int b;
    bit stall;
    @(negedge clk);
    s_arvalid = 3'b001; s_araddr[0 +: 32] = 32'h0000_6000; s_arlen[0 +: 4] = 4'd3; s_rready = 3'b001;
    @(negedge clk); #1;
    n_cmp++;
    if (m_arvalid !== 1'b1) begin
      n_err++; $display("FAIL bp_arvalid: got %b want 1", m_arvalid);
    end
    m_arready = 1;
    @(negedge clk); m_arready = 0; s_arvalid = '0;
    rx = 0; b = 0;
    for (int cyc = 0; cyc < 30 && rx < 4; cyc++) begin
      stall = (cyc >= 1 && cyc <= 5);
      s_rready[0] = !stall;
      m_rvalid = 1; m_rdata = 32'hB0 + 32'(b); m_rlast = (b == 3); #1;
      n_cmp++;
      if ({m_rready, s_rvalid[0]} !== {!stall, 1'b1}) begin
        n_err++; $display("FAIL bp_rready_c%0d: rready %b rvalid %b want %b 1", cyc, m_rready, s_rvalid[0], !stall);
      end
      if (m_rready) begin
        n_cmp++;
        if ({s_rdata[0 +: 32], s_rlast[0]} !== {32'hB0 + 32'(rx), (rx == 3)}) begin
          n_err++; $display("FAIL bp_beat%0d: data %h last %b want %h %b", rx, s_rdata[0 +: 32], s_rlast[0],
                            32'hB0 + 32'(rx), (rx == 3));
        end
        rx++; b++;
      end
      @(negedge clk);
    end
    m_rvalid = 0; m_rlast = 0; s_rready = 3'b001; #1;
    n_cmp++;
    if ({32'(rx), m_rready} !== {32'd4, 1'b0}) begin
      n_err++; $display("FAIL bp_complete: beats %0d rready %b want 4 0", rx, m_rready);
    end
    s_rready = '0;
    $display("txn read master=0 backpressure beats=%0d", rx);
  endtask

  initial begin
    s_arid = 12'h210; s_awid = 12'h210; s_wid = 12'h210;
    s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arlock = '0;
    s_arcache = '0; s_arprot = '0;
    s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awlock = '0;
    s_awcache = '0; s_awprot = '0; s_wdata = '0; s_wstrb = '0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_reset_mid_burst();
    test_arbitration();
    test_write_w_before_aw();
    test_concurrent();
    test_backpressure();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
